// File: rtl/rca_config_loader_pkg.sv
// Shared sizing, FSM encoding and command/write record types for the RCA
// configuration loader and its helpers.
package rca_config_loader_pkg;

    localparam int NUM_RCAS        = 4;
    localparam int NUM_READ_PORTS  = 4;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int ADDR_W          = 5;

    localparam int RCA_SEL_W  = $clog2(NUM_RCAS);
    localparam int SRC_SEL_W  = $clog2(NUM_READ_PORTS);
    localparam int DEST_SEL_W = $clog2(NUM_WRITE_PORTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SRC,
        S_WR_DEST,
        S_DONE,
        S_ERR
    } cfg_state_t;

    typedef struct packed {
        logic [RCA_SEL_W-1:0]              rca_sel;
        logic [ADDR_W*NUM_READ_PORTS-1:0]  src_addrs;
        logic [ADDR_W*NUM_WRITE_PORTS-1:0] dest_addrs;
        logic [NUM_READ_PORTS-1:0]         src_mask;
        logic [NUM_WRITE_PORTS-1:0]        dest_mask;
    } rca_cfg_cmd_t;

    typedef struct packed {
        logic                  wr_en;
        logic [RCA_SEL_W-1:0]  rca_sel_w;
        logic [SRC_SEL_W-1:0]  src_port_sel;
        logic [DEST_SEL_W-1:0] dest_port_sel;
        logic                  src_dest_port;
        logic [ADDR_W-1:0]     reg_addr;
    } rca_cfg_wr_t;

endpackage

// File: rtl/rca_cfg_port_picker.sv
// Finds the lowest set bit of a port mask: presence flag, its index and a
// one-hot copy used to clear it once the port has been written.
module rca_cfg_port_picker #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         mask_i,
    output logic                     any_o,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic [WIDTH-1:0]         onehot_o
);

    localparam int IW = $clog2(WIDTH);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign onehot_o = mask_i & (~mask_i + WIDTH'(1));
    assign any_o    = |mask_i;

endmodule

// File: rtl/rca_config_loader.sv
// Serialises one whole-RCA configuration command into single-port register
// writes and tracks which RCAs currently hold a complete configuration.
module rca_config_loader #(
    parameter int NUM_RCAS        = rca_config_loader_pkg::NUM_RCAS,
    parameter int NUM_READ_PORTS  = rca_config_loader_pkg::NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = rca_config_loader_pkg::NUM_WRITE_PORTS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [$clog2(NUM_RCAS)-1:0]        cfg_rca_sel,
    input  logic [5*NUM_READ_PORTS-1:0]        cfg_src_addrs,
    input  logic [5*NUM_WRITE_PORTS-1:0]       cfg_dest_addrs,
    input  logic [NUM_READ_PORTS-1:0]          cfg_src_mask,
    input  logic [NUM_WRITE_PORTS-1:0]         cfg_dest_mask,
    output logic                               cfg_done,
    output logic                               cfg_error,
    output logic [NUM_RCAS-1:0]                rca_configured,
    output logic                               wr_en,
    output logic [$clog2(NUM_RCAS)-1:0]        rca_sel_w,
    output logic [$clog2(NUM_READ_PORTS)-1:0]  src_port_sel,
    output logic [$clog2(NUM_WRITE_PORTS)-1:0] dest_port_sel,
    output logic                               src_dest_port,
    output logic [4:0]                         reg_addr
);

    import rca_config_loader_pkg::*;

    localparam int RSW = $clog2(NUM_RCAS);

    cfg_state_t                 state_q, state_d;
    rca_cfg_cmd_t               cmd_q, cmd_d, cmd_in, work;
    rca_cfg_wr_t                wr_q, wr_d;
    logic                       ready_q, ready_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [NUM_RCAS-1:0]        cfg_q, cfg_d;
    logic                       accept, oor, load;
    logic                       src_any, dest_any;
    logic [SRC_SEL_W-1:0]       src_idx;
    logic [DEST_SEL_W-1:0]      dest_idx;
    logic [NUM_READ_PORTS-1:0]  src_oh;
    logic [NUM_WRITE_PORTS-1:0] dest_oh;

    assign accept = cfg_valid && ready_q;
    assign oor    = (32'(cfg_rca_sel) >= 32'(NUM_RCAS));

    always_comb begin
        cmd_in            = '0;
        cmd_in.rca_sel    = cfg_rca_sel;
        cmd_in.src_addrs  = cfg_src_addrs;
        cmd_in.dest_addrs = cfg_dest_addrs;
        cmd_in.src_mask   = cfg_src_mask;
        cmd_in.dest_mask  = cfg_dest_mask;
    end

    // The first write is registered on the accept edge, so pick from the
    // incoming command while idle and from the latched remainder otherwise.
    assign work = (state_q == S_IDLE) ? cmd_in : cmd_q;

    rca_cfg_port_picker #(.WIDTH(NUM_READ_PORTS)) u_src_pick (
        .mask_i   (work.src_mask),
        .any_o    (src_any),
        .idx_o    (src_idx),
        .onehot_o (src_oh)
    );

    rca_cfg_port_picker #(.WIDTH(NUM_WRITE_PORTS)) u_dest_pick (
        .mask_i   (work.dest_mask),
        .any_o    (dest_any),
        .idx_o    (dest_idx),
        .onehot_o (dest_oh)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wr_d    = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cfg_d   = cfg_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    cmd_d   = cmd_in;
                    if (oor) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        load = 1'b1;
                        for (int i = 0; i < NUM_RCAS; i++) begin
                            if (cfg_rca_sel == RSW'(i)) cfg_d[i] = 1'b0;
                        end
                    end
                end
            end
            S_WR_SRC, S_WR_DEST: load = 1'b1;
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                for (int i = 0; i < NUM_RCAS; i++) begin
                    if (cmd_q.rca_sel == RSW'(i)) cfg_d[i] = 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Empty masks fall straight through, so no cycle is spent on them.
        if (load) begin
            if (src_any) begin
                state_d            = S_WR_SRC;
                wr_d.wr_en         = 1'b1;
                wr_d.rca_sel_w     = work.rca_sel;
                wr_d.src_port_sel  = src_idx;
                wr_d.reg_addr      = work.src_addrs[src_idx*ADDR_W +: ADDR_W];
                cmd_d.src_mask     = work.src_mask & ~src_oh;
            end else if (dest_any) begin
                state_d            = S_WR_DEST;
                wr_d.wr_en         = 1'b1;
                wr_d.rca_sel_w     = work.rca_sel;
                wr_d.dest_port_sel = dest_idx;
                wr_d.src_dest_port = 1'b1;
                wr_d.reg_addr      = work.dest_addrs[dest_idx*ADDR_W +: ADDR_W];
                cmd_d.dest_mask    = work.dest_mask & ~dest_oh;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
        end
    end

    // Command payload is only consumed after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        cmd_q <= cmd_d;
    end

    assign cfg_ready      = ready_q;
    assign cfg_done       = done_q;
    assign cfg_error      = err_q;
    assign rca_configured = cfg_q;
    assign wr_en          = wr_q.wr_en;
    assign rca_sel_w      = wr_q.rca_sel_w;
    assign src_port_sel   = wr_q.src_port_sel;
    assign dest_port_sel  = wr_q.dest_port_sel;
    assign src_dest_port  = wr_q.src_dest_port;
    assign reg_addr       = wr_q.reg_addr;

endmodule

// File: tb/tb_rca_config_loader.sv
// Bench for rca_config_loader: transaction-level reference model, vector table,
// randomized commands and hand sequences for reset, back-to-back and bad targets.
module tb_rca_config_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default sizing
    logic        a_valid = 1'b0, a_ready, a_done, a_err, a_wr, a_dp, a_sd;
    logic [1:0]  a_sel = '0, a_rsel, a_sp;
    logic [19:0] a_src = '0;
    logic [9:0]  a_dst = '0;
    logic [3:0]  a_sm = '0, a_cfg;
    logic [1:0]  a_dm = '0;
    logic [4:0]  a_addr;

    // DUT B: three RCAs, so select value 3 is out of range
    logic        b_valid = 1'b0, b_ready, b_done, b_err, b_wr, b_dp, b_sd;
    logic [1:0]  b_sel = '0, b_rsel, b_sp;
    logic [19:0] b_src = '0;
    logic [9:0]  b_dst = '0;
    logic [3:0]  b_sm = '0;
    logic [1:0]  b_dm = '0;
    logic [2:0]  b_cfg;
    logic [4:0]  b_addr;

    rca_config_loader dut_a (
        .clk(clk), .rst(rst), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_rca_sel(a_sel), .cfg_src_addrs(a_src), .cfg_dest_addrs(a_dst),
        .cfg_src_mask(a_sm), .cfg_dest_mask(a_dm), .cfg_done(a_done),
        .cfg_error(a_err), .rca_configured(a_cfg), .wr_en(a_wr),
        .rca_sel_w(a_rsel), .src_port_sel(a_sp), .dest_port_sel(a_dp),
        .src_dest_port(a_sd), .reg_addr(a_addr)
    );

    rca_config_loader #(.NUM_RCAS(3)) dut_b (
        .clk(clk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_rca_sel(b_sel), .cfg_src_addrs(b_src), .cfg_dest_addrs(b_dst),
        .cfg_src_mask(b_sm), .cfg_dest_mask(b_dm), .cfg_done(b_done),
        .cfg_error(b_err), .rca_configured(b_cfg), .wr_en(b_wr),
        .rca_sel_w(b_rsel), .src_port_sel(b_sp), .dest_port_sel(b_dp),
        .src_dest_port(b_sd), .reg_addr(b_addr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one expected output record per cycle, queued at accept.
    typedef struct {
        logic       ready, done, err, wr;
        logic [1:0] rca, sp;
        logic       dp, sd;
        logic [4:0] addr;
        int         set_idx;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [3:0] m_cfg = '0;
    bit         model_live = 0;

    function automatic exp_t idle_rec();
        exp_t e;
        e = '{ready: 1'b1, done: 1'b0, err: 1'b0, wr: 1'b0, rca: 2'd0, sp: 2'd0,
              dp: 1'b0, sd: 1'b0, addr: 5'd0, set_idx: -1};
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            q.delete();
            cur        = idle_rec();
            m_cfg      = '0;
            model_live = 1;
        end else if (model_live) begin
            if (cur.ready && a_valid) begin
                exp_t e;
                m_cfg[a_sel] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (a_sm[i]) begin
                        e = idle_rec();
                        e.ready = 1'b0; e.wr = 1'b1; e.rca = a_sel; e.sp = 2'(i);
                        e.addr = 5'((a_src >> (5 * i)) & 20'h1f);
                        q.push_back(e);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (a_dm[i]) begin
                        e = idle_rec();
                        e.ready = 1'b0; e.wr = 1'b1; e.rca = a_sel; e.sd = 1'b1;
                        e.dp = 1'(i);
                        e.addr = 5'((a_dst >> (5 * i)) & 10'h1f);
                        q.push_back(e);
                    end
                end
                e = idle_rec();
                e.ready = 1'b0; e.done = 1'b1; e.set_idx = int'(a_sel);
                q.push_back(e);
            end
            if (cur.set_idx >= 0) m_cfg[cur.set_idx] = 1'b1;
            cur = (q.size() > 0) ? q.pop_front() : idle_rec();
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("model_outputs",
                {a_ready, a_done, a_err, a_wr, a_rsel, a_sp, a_dp, a_sd, a_addr, a_cfg},
                {cur.ready, cur.done, cur.err, cur.wr, cur.rca, cur.sp, cur.dp, cur.sd,
                 cur.addr, m_cfg});
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic send(input logic [1:0] sel, input logic [19:0] src, input logic [9:0] dst,
                        input logic [3:0] sm, input logic [1:0] dm, output int acc);
        a_sel = sel; a_src = src; a_dst = dst; a_sm = sm; a_dm = dm; a_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 64 && acc < 0; k++) begin
            if (a_ready) acc = cyc;
            else @(negedge clk);
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: no cfg_ready within 64 cycles (cycle %0d)", cyc);
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [19:0] src;
        logic [9:0]  dst;
        logic [3:0]  sm;
        logic [1:0]  dm;
        int          nwr, done_off, first_addr, last_addr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int acc, nwr, done_off, rdy_off, first, last, acc1, acc2, done1;
        logic cfg_at_done, cfg_at_rdy;

        tbl[0] = '{2'd2, {5'd8, 5'd7, 5'd6, 5'd5}, {5'd10, 5'd9}, 4'hF, 2'b11, 6, 7, 5, 10};
        tbl[1] = '{2'd0, {5'd12, 5'd0, 5'd11, 5'd0}, {5'd13, 5'd0}, 4'b1010, 2'b10, 3, 4, 11, 13};
        tbl[2] = '{2'd1, 20'h12345, 10'h155, 4'b0000, 2'b00, 0, 1, 0, 0};
        tbl[3] = '{2'd3, 20'hABCDE, {5'd0, 5'd31}, 4'b0000, 2'b01, 1, 2, 31, 31};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset_ready_a", a_ready, 1);
        chk("reset_idle_a", {a_done, a_err, a_wr, a_rsel, a_sp, a_dp, a_sd, a_addr}, 0);
        chk("reset_cfg_a", a_cfg, 0);
        chk("reset_ready_b", b_ready, 1);
        chk("reset_idle_b", {b_done, b_err, b_wr, b_cfg}, 0);

        // DUT B: empty in-range load, then an out-of-range target
        b_sel = 2'd0; b_sm = '0; b_dm = '0; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_empty_done", b_done, 1);
        @(negedge clk);
        chk("b_empty_cfg", b_cfg, 3'b001);
        chk("b_empty_ready", b_ready, 1);
        b_sel = 2'd3; b_src = 20'hFFFFF; b_dst = 10'h3FF; b_sm = 4'hF; b_dm = 2'b11;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("oor_error_pulse", {b_err, b_done, b_wr, b_ready}, 4'b1000);
        @(negedge clk);
        chk("oor_ready_back", {b_err, b_done, b_wr, b_ready}, 4'b0001);
        chk("oor_cfg_unchanged", b_cfg, 3'b001);
        @(negedge clk);
        chk("oor_no_late_write", {b_wr, b_cfg}, 4'b0001);

        // Vector table on DUT A
        for (int v = 0; v < 4; v++) begin
            send(tbl[v].sel, tbl[v].src, tbl[v].dst, tbl[v].sm, tbl[v].dm, acc);
            nwr = 0; done_off = -1; rdy_off = -1; first = -1; last = -1;
            cfg_at_done = 1'bx; cfg_at_rdy = 1'bx;
            for (int off = 1; off <= 12; off++) begin
                if (a_wr) begin
                    nwr++;
                    if (first < 0) first = int'(a_addr);
                    last = int'(a_addr);
                end
                if (a_done && done_off < 0) begin
                    done_off = off; cfg_at_done = a_cfg[tbl[v].sel];
                end
                if (a_ready && rdy_off < 0) begin
                    rdy_off = off; cfg_at_rdy = a_cfg[tbl[v].sel];
                end
                @(negedge clk);
            end
            chk($sformatf("vec%0d_writes", v), nwr, tbl[v].nwr);
            chk($sformatf("vec%0d_done_cycle", v), done_off, tbl[v].done_off);
            chk($sformatf("vec%0d_ready_cycle", v), rdy_off, tbl[v].done_off + 1);
            chk($sformatf("vec%0d_cfg_during", v), cfg_at_done, 0);
            chk($sformatf("vec%0d_cfg_after", v), cfg_at_rdy, 1);
            if (tbl[v].nwr > 0) begin
                chk($sformatf("vec%0d_first_addr", v), first, tbl[v].first_addr);
                chk($sformatf("vec%0d_last_addr", v), last, tbl[v].last_addr);
            end
        end

        // Back-to-back with cfg_valid held high
        a_sel = 2'd1; a_src = {5'd12, 5'd0, 5'd11, 5'd0}; a_dst = {5'd13, 5'd0};
        a_sm = 4'b1010; a_dm = 2'b10; a_valid = 1'b1;
        acc1 = -1; acc2 = -1; done1 = -1; nwr = 0;
        for (int k = 0; k < 30; k++) begin
            if (a_wr) nwr++;
            if (a_done && done1 < 0) done1 = cyc;
            if (a_valid && a_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            @(negedge clk);
            if (acc2 >= 0) a_valid = 1'b0;
        end
        chk("b2b_second_accept", acc2 - done1, 1);
        chk("b2b_total_writes", nwr, 6);

        // Reset in cycle 2 of a full load
        send(2'd2, {5'd8, 5'd7, 5'd6, 5'd5}, {5'd10, 5'd9}, 4'hF, 2'b11, acc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr", a_wr, 0);
        chk("rst_mid_cfg", a_cfg, 0);
        chk("rst_mid_ready", a_ready, 1);
        rst = 1'b1;
        nwr = 0;
        repeat (8) begin
            if (a_wr) nwr++;
            @(negedge clk);
        end
        chk("rst_mid_no_writes", nwr, 0);

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(2'($urandom_range(0, 3)), 20'($urandom), 10'($urandom),
                 4'($urandom), 2'($urandom), acc);
        end
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rca_config_loader.md
Name: rca_config_loader

Overview:
- Writer-side sequencer for the RCA configuration register file.
- Accepts one whole-RCA configuration command (all source and destination register addresses, plus a per-port write mask) over a valid/ready handshake.
- Serialises the command into single-port writes on the config-register write interface, one write per cycle.
- Tracks which RCAs hold a complete configuration so issue logic can block dispatch to a partially written RCA.

Parameters:
- NUM_RCAS, 4, number of RCAs (must be ≥2).
- NUM_READ_PORTS, 4, source register ports per RCA (must be ≥2).
- NUM_WRITE_PORTS, 2, destination register ports per RCA (must be ≥2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  loader can accept a command.
- cfg_rca_sel  in  $clog2(NUM_RCAS)  target RCA.
- cfg_src_addrs  in  5*NUM_READ_PORTS  packed source addresses; port i = bits [5i+4:5i].
- cfg_dest_addrs  in  5*NUM_WRITE_PORTS  packed destination addresses, same packing.
- cfg_src_mask  in  NUM_READ_PORTS  1 = write that source port.
- cfg_dest_mask  in  NUM_WRITE_PORTS  1 = write that destination port.
- cfg_done  out  1  one-cycle pulse when a command completes.
- cfg_error  out  1  one-cycle pulse when a command is dropped.
- rca_configured  out  NUM_RCAS  per-RCA "configuration complete" flag.
- wr_en  out  1  write strobe to the config regs.
- rca_sel_w  out  $clog2(NUM_RCAS)  RCA being written.
- src_port_sel  out  $clog2(NUM_READ_PORTS)  source port index.
- dest_port_sel  out  $clog2(NUM_WRITE_PORTS)  destination port index.
- src_dest_port  out  1  0 = source write, 1 = destination write.
- reg_addr  out  5  address value being written.

Behaviour:
- **Reset** (rst=0 at posedge):
  - State goes to IDLE.
  - cfg_ready=1 after reset; cfg_done=0, cfg_error=0, wr_en=0.
  - All write-side outputs are 0.
  - rca_configured is all-zero, matching the zeroed contents of the config regs.
  - Reset mid-command aborts the command with no further writes.
- **Outputs:**
  - All outputs are registered.
  - When wr_en=0, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port and reg_addr are driven 0.
- **Handshake:**
  - Transfer occurs when cfg_valid && cfg_ready at a posedge (cycle N).
  - The command is latched internally.
  - cfg_ready=1 only in IDLE.
  - Inputs are don't-care when cfg_valid=0.
- **FSM:**
  - IDLE → WR_SRC on accept.
  - WR_SRC: each cycle, write the lowest remaining set src_mask bit.
    - wr_en=1, src_dest_port=0, src_port_sel=index, reg_addr=field.
    - Clear that bit. When no bits remain, go to WR_DEST.
  - WR_DEST: same procedure over dest_mask with src_dest_port=1; when empty, go to DONE.
  - Empty masks are skipped without spending a cycle. With both masks zero, the first cycle after accept is DONE.
  - DONE: one cycle; cfg_done=1, wr_en=0; next state IDLE.
- **Latency:**
  - With P = popcount(src_mask) + popcount(dest_mask), writes occupy cycles N+1 .. N+P.
  - cfg_done is asserted in cycle N+1+P.
  - cfg_ready returns in cycle N+2+P.
- **rca_configured:**
  - Target bit reads 0 from cycle N+1, for the whole load.
  - Target bit reads 1 from cycle N+2+P.
  - Other bits are unchanged.
- **Out-of-range target** (cfg_rca_sel ≥ NUM_RCAS):
  - The command is accepted.
  - No writes are issued and rca_configured is unchanged.
  - cfg_error pulses in cycle N+1; cfg_done does not pulse.
  - cfg_ready returns in cycle N+2.
- **Back-to-back commands:** cfg_valid held high is accepted again in the first cycle cfg_ready=1. There is no pipelining across commands.

Decomposition:
- Shared rca_config package holds:
  - NUM_RCAS, NUM_READ_PORTS, NUM_WRITE_PORTS.
  - typedef rca_cfg_cmd_t (rca_sel, src_addrs, dest_addrs, src_mask, dest_mask).
  - typedef rca_cfg_wr_t (the six write-side fields).
- One sub-module, rca_cfg_port_picker, parameterised by width:
  - Inputs: mask.
  - Outputs: any, index of lowest set bit, one-hot of that bit.
  - Instantiated once for src and once for dest.

Test Plan:
All scenarios use the default parameters.
- **Full load:** rca 2, src {5,6,7,8}, dest {9,10}, masks all-1, accept cycle 0 → writes in cycles 1-4 are src ports 0..3 with addrs 5..8; cycles 5-6 are dest ports 0,1 with addrs 9,10; cfg_done in cycle 7; rca_configured[2] is 0 in cycles 1-7 and 1 from cycle 8; cfg_ready=1 in cycle 8.
- **Sparse masks:** src_mask=4'b1010 (addrs 11,12 at ports 1,3), dest_mask=2'b10 (addr 13) → exactly three writes: (src,1,11), (src,3,12), (dest,1,13); cfg_done in cycle 4.
- **Empty masks:** src_mask=0, dest_mask=0, rca 1 → no wr_en; cfg_done in cycle 1; rca_configured[1]=1 from cycle 2.
- **Out-of-range target:** cfg_rca_sel=3 is legal in the default config; use NUM_RCAS=3 with sel=3 → no wr_en; cfg_error in cycle 1; rca_configured unchanged; ready in cycle 2.
- **Back-to-back:** cfg_valid held high for two full commands → second accept occurs in the cycle after the first cfg_done; no gap or overlap between write bursts apart from the DONE cycle.
- **Reset mid-load:** rst=0 in cycle 2 of a full load → from the next cycle, wr_en=0, rca_configured all-zero, cfg_ready=1; no further writes.
